// File: rtl/slip_frame_filter_pkg.sv
// Shared SLIP framing constants, drop reason codes and receive-state encoding
// for the SLIP frame filter.
package slip_frame_filter_pkg;

   localparam logic [7:0] SYMBOL_END     = 8'hC0;
   localparam logic [7:0] SYMBOL_ESC     = 8'hDB;
   localparam logic [7:0] SYMBOL_ESC_END = 8'hDC;
   localparam logic [7:0] SYMBOL_ESC_ESC = 8'hDD;

   localparam logic [1:0] DROP_CRC  = 2'd0;
   localparam logic [1:0] DROP_OVF  = 2'd1;
   localparam logic [1:0] DROP_RUNT = 2'd2;

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_RECV,
      ST_OVF
   } rx_state_t;

endpackage

// File: rtl/slip_frame_filter_sdp_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// The read register holds its value while re is low.
module sdp_ram #(
   parameter int WIDTH = 9,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/slip_frame_filter.sv
// Store-and-forward SLIP frame validator: buffers each frame, checks its
// trailing CRC and forwards only good payloads (CRC stripped) downstream.
module slip_frame_filter
   import slip_frame_filter_pkg::*;
#(
   parameter int                      SYMBOL_WIDTH = 8,
   parameter logic [SYMBOL_WIDTH-1:0] CRC_POLY     = 'h07,
   parameter int                      ADDR_W       = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SYMBOL_WIDTH-1:0] i_data,
   input  logic                    i_mark,
   input  logic                    i_valid,
   output logic                    o_ready,
   output logic [SYMBOL_WIDTH-1:0] o_data,
   output logic                    o_last,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic                    o_evt_ok,
   output logic                    o_evt_drop,
   output logic [1:0]              o_drop_reason
);

   localparam int              SW      = SYMBOL_WIDTH;
   localparam logic [ADDR_W-1:0] PTR_ONE = 1;

   function automatic logic [SW-1:0] crc_step(input logic [SW-1:0] c, input logic [SW-1:0] d);
      logic [SW-1:0] r;
      r = c ^ d;
      for (int i = 0; i < SW; i++)
         r = r[SW-1] ? ((r << 1) ^ CRC_POLY) : (r << 1);
      return r;
   endfunction

   rx_state_t         state, state_nx;
   logic [SW-1:0]     h0, h1, crc;
   logic [1:0]        n;
   logic [ADDR_W-1:0] wr_ptr, commit_ptr, rd_ptr;

   logic              sym_xfer, mark_xfer, full;
   logic              shift, frame_rst, wr_adv, commit, rewind;
   logic              we;
   logic [SW:0]       wdata;
   logic              evt_ok_nx, evt_drop_nx;
   logic [1:0]        reason_nx;

   logic              rd_issue, ram_vld, load_out, out_free;
   logic [SW:0]       rdata;

   assign sym_xfer  = i_valid && o_ready && !i_mark;
   assign mark_xfer = i_valid && o_ready && i_mark;
   assign full      = (wr_ptr + PTR_ONE) == rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_SYNC;
         o_ready <= 1'b0;
      end else begin
         state   <= state_nx;
         o_ready <= 1'b1;
      end
   end

   always_comb begin
      state_nx    = state;
      shift       = 1'b0;
      frame_rst   = 1'b0;
      wr_adv      = 1'b0;
      commit      = 1'b0;
      rewind      = 1'b0;
      we          = 1'b0;
      wdata       = {1'b0, h1};
      evt_ok_nx   = 1'b0;
      evt_drop_nx = 1'b0;
      reason_nx   = o_drop_reason;
      case (state)
         ST_SYNC: begin
            if (mark_xfer) begin
               state_nx  = ST_RECV;
               frame_rst = 1'b1;
            end
         end
         ST_RECV: begin
            if (sym_xfer) begin
               if (n == 2'd2 && full) begin
                  state_nx = ST_OVF;
               end else begin
                  shift = 1'b1;
                  if (n == 2'd2) begin
                     we     = 1'b1;
                     wr_adv = 1'b1;
                  end
               end
            end else if (mark_xfer) begin
               frame_rst = 1'b1;
               // h0 holds the CRC symbol, h1 the final payload symbol
               if (n == 2'd1) begin
                  rewind      = 1'b1;
                  evt_drop_nx = 1'b1;
                  reason_nx   = DROP_RUNT;
               end else if (n == 2'd2) begin
                  if (crc != '0) begin
                     rewind      = 1'b1;
                     evt_drop_nx = 1'b1;
                     reason_nx   = DROP_CRC;
                  end else if (full) begin
                     rewind      = 1'b1;
                     evt_drop_nx = 1'b1;
                     reason_nx   = DROP_OVF;
                  end else begin
                     we        = 1'b1;
                     wdata     = {1'b1, h1};
                     commit    = 1'b1;
                     evt_ok_nx = 1'b1;
                  end
               end
            end
         end
         ST_OVF: begin
            if (mark_xfer) begin
               state_nx    = ST_RECV;
               frame_rst   = 1'b1;
               rewind      = 1'b1;
               evt_drop_nx = 1'b1;
               reason_nx   = DROP_OVF;
            end
         end
         default: state_nx = ST_SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h0  <= '0;
         h1  <= '0;
         crc <= '0;
         n   <= 2'd0;
      end else if (frame_rst) begin
         crc <= '0;
         n   <= 2'd0;
      end else if (shift) begin
         h0  <= i_data;
         h1  <= h0;
         crc <= crc_step(crc, i_data);
         n   <= (n == 2'd2) ? 2'd2 : n + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         commit_ptr    <= '0;
         o_evt_ok      <= 1'b0;
         o_evt_drop    <= 1'b0;
         o_drop_reason <= 2'd0;
      end else begin
         if (rewind)
            wr_ptr <= commit_ptr;
         else if (wr_adv || commit)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (commit)
            commit_ptr <= wr_ptr + PTR_ONE;
         o_evt_ok      <= evt_ok_nx;
         o_evt_drop    <= evt_drop_nx;
         o_drop_reason <= reason_nx;
      end
   end

   sdp_ram #(.WIDTH(SW + 1), .AW(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr),
      .wdata (wdata),
      .re    (rd_issue),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   // Two-stage read: RAM output register then output register; a new read is
   // issued only when the RAM register is empty or draining this cycle.
   assign out_free = !o_valid || i_ready;
   assign load_out = ram_vld && out_free;
   assign rd_issue = (rd_ptr != commit_ptr) && (!ram_vld || load_out);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         ram_vld <= 1'b0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_last  <= 1'b0;
      end else begin
         if (rd_issue) rd_ptr <= rd_ptr + PTR_ONE;
         ram_vld <= rd_issue || (ram_vld && !load_out);
         if (load_out) begin
            o_valid <= 1'b1;
            o_data  <= rdata[SW-1:0];
            o_last  <= rdata[SW];
         end else if (i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_slip_frame_filter.sv
// Scoreboard bench for slip_frame_filter (ADDR_W=4 so overflow is reachable).
module tb_slip_frame_filter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] i_data;
   logic       i_mark, i_valid, i_ready;
   logic       o_ready, o_last, o_valid, o_evt_ok, o_evt_drop;
   logic [7:0] o_data;
   logic [1:0] o_drop_reason;

   slip_frame_filter #(.SYMBOL_WIDTH(8), .CRC_POLY(8'h07), .ADDR_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_mark(i_mark), .i_valid(i_valid),
      .o_ready(o_ready), .o_data(o_data), .o_last(o_last), .o_valid(o_valid),
      .i_ready(i_ready), .o_evt_ok(o_evt_ok), .o_evt_drop(o_evt_drop),
      .o_drop_reason(o_drop_reason)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [8:0] sb[$];
   logic [7:0] frm[$];
   int         ok_cnt = 0, drop_cnt = 0, ok_cyc = 0, vrise_cyc = 0;
   logic [1:0] last_reason = 2'd3;
   logic       prev_valid = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard and event monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_evt_ok) begin ok_cnt++; ok_cyc = cyc; end
         if (o_evt_drop) begin drop_cnt++; last_reason = o_drop_reason; end
         if (o_valid && !prev_valid) vrise_cyc = cyc;
         prev_valid = o_valid;
         if (o_valid && i_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output: got data=%02h last=%0b, none expected", o_data, o_last);
            end else begin
               logic [8:0] e;
               e = sb.pop_front();
               if ({o_last, o_data} !== e) begin
                  n_fail++;
                  $display("FAIL output_symbol: got data=%02h last=%0b, want data=%02h last=%0b",
                           o_data, o_last, e[7:0], e[8]);
               end
            end
         end
      end else begin
         prev_valid = 1'b0;
      end
   end

   function automatic logic [7:0] crc8(input logic [7:0] q[$]);
      logic [7:0] c;
      c = 8'h00;
      foreach (q[k]) begin
         c = c ^ q[k];
         for (int b = 0; b < 8; b++) c = c[7] ? {c[6:0], 1'b0} ^ 8'h07 : {c[6:0], 1'b0};
      end
      return c;
   endfunction

   task automatic drive(input logic m, input logic [7:0] d);
      i_valid = 1'b1; i_mark = m; i_data = d;
      @(posedge clk); #1;
      i_valid = 1'b0; i_mark = 1'b0;
   endtask

   // Sends mark, frm payload, CRC (optionally corrupted), mark
   task automatic send_frame(input bit corrupt, input bit expect_ok);
      logic [7:0] c;
      c = crc8(frm);
      if (corrupt) c = c ^ 8'h01;
      if (expect_ok)
         foreach (frm[k]) sb.push_back({(k == frm.size() - 1), frm[k]});
      drive(1'b1, 8'h00);
      foreach (frm[k]) drive(1'b0, frm[k]);
      drive(1'b0, c);
      drive(1'b1, 8'h00);
   endtask

   task automatic wait_drain(input string tag);
      int k;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && !o_valid) break;
      end
      @(posedge clk); #1;
      n_checks++;
      if (k >= 300) begin
         n_fail++;
         $display("FAIL %s_drain_timeout: %0d symbols still expected", tag, sb.size());
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      n_checks++;
      if ({o_valid, o_last, o_evt_ok, o_evt_drop, o_ready, o_data, o_drop_reason} !== 15'd0) begin
         n_fail++;
         $display("FAIL %s: got valid=%0b last=%0b ok=%0b drop=%0b ready=%0b data=%02h reason=%0d, want all 0",
                  tag, o_valid, o_last, o_evt_ok, o_evt_drop, o_ready, o_data, o_drop_reason);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_valid = 1'b0; i_mark = 1'b0; i_data = 8'h00; i_ready = 1'b1;
      #1;
      check_reset_outputs("reset_outputs");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (o_ready !== 1'b1) begin
         n_fail++; $display("FAIL ready_after_reset: got %0b want 1", o_ready);
      end
   endtask

   task automatic test_good_frame();
      int ok0, dr0;
      ok0 = ok_cnt; dr0 = drop_cnt;
      sb.push_back({1'b0, 8'h01}); sb.push_back({1'b0, 8'h02}); sb.push_back({1'b1, 8'h03});
      drive(1'b1, 8'h00); drive(1'b0, 8'h01); drive(1'b0, 8'h02);
      drive(1'b0, 8'h03); drive(1'b0, 8'h48); drive(1'b1, 8'h00);
      wait_drain("good");
      n_checks++;
      if (ok_cnt - ok0 !== 1 || drop_cnt - dr0 !== 0) begin
         n_fail++; $display("FAIL good_events: got ok=%0d drop=%0d want ok=1 drop=0", ok_cnt - ok0, drop_cnt - dr0);
      end
      n_checks++;
      if (vrise_cyc - ok_cyc !== 2) begin
         n_fail++; $display("FAIL good_latency: got %0d cycles want 2", vrise_cyc - ok_cyc);
      end
   endtask

   task automatic test_bad_crc();
      int ok0, dr0;
      ok0 = ok_cnt; dr0 = drop_cnt;
      drive(1'b1, 8'h00); drive(1'b0, 8'h01); drive(1'b0, 8'h02);
      drive(1'b0, 8'h03); drive(1'b0, 8'h49); drive(1'b1, 8'h00);
      repeat (6) @(posedge clk); #1;
      n_checks++;
      if (drop_cnt - dr0 !== 1 || last_reason !== 2'd0 || ok_cnt != ok0 || o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL crc_drop: got drops=%0d reason=%0d oks=%0d valid=%0b want 1,0,0,0",
                  drop_cnt - dr0, last_reason, ok_cnt - ok0, o_valid);
      end
      frm = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
      send_frame(1'b0, 1'b1);
      wait_drain("after_crc");
   endtask

   task automatic test_runt_and_empty();
      int ok0, dr0;
      ok0 = ok_cnt; dr0 = drop_cnt;
      drive(1'b1, 8'h00); drive(1'b0, 8'h55); drive(1'b1, 8'h00);
      repeat (3) @(posedge clk); #1;
      n_checks++;
      if (drop_cnt - dr0 !== 1 || last_reason !== 2'd2) begin
         n_fail++; $display("FAIL runt_drop: got drops=%0d reason=%0d want 1,2", drop_cnt - dr0, last_reason);
      end
      dr0 = drop_cnt;
      drive(1'b1, 8'h00); drive(1'b1, 8'h00);
      repeat (5) @(posedge clk); #1;
      n_checks++;
      if (drop_cnt != dr0 || ok_cnt != ok0 || o_valid !== 1'b0) begin
         n_fail++; $display("FAIL empty_frame: got drops=%0d oks=%0d valid=%0b want 0,0,0",
                            drop_cnt - dr0, ok_cnt - ok0, o_valid);
      end
   endtask

   task automatic test_overflow();
      int ok0, dr0;
      ok0 = ok_cnt; dr0 = drop_cnt;
      frm.delete();
      for (int k = 0; k < 19; k++) frm.push_back(8'(k + 16));
      send_frame(1'b0, 1'b0);
      repeat (4) @(posedge clk); #1;
      n_checks++;
      if (drop_cnt - dr0 !== 1 || last_reason !== 2'd1 || ok_cnt != ok0 || o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_drop: got drops=%0d reason=%0d oks=%0d valid=%0b want 1,1,0,0",
                  drop_cnt - dr0, last_reason, ok_cnt - ok0, o_valid);
      end
      frm = '{8'h01, 8'h02, 8'h03};
      send_frame(1'b0, 1'b1);
      wait_drain("after_ovf");
      n_checks++;
      if (ok_cnt - ok0 !== 1) begin
         n_fail++; $display("FAIL after_ovf_ok: got %0d want 1", ok_cnt - ok0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d0;
      logic       l0;
      i_ready = 1'b0;
      frm = '{8'hA1, 8'hA2};
      send_frame(1'b0, 1'b1);
      frm = '{8'hB1, 8'hB2, 8'hB3};
      send_frame(1'b0, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      d0 = o_data; l0 = o_last;
      n_checks++;
      if (o_valid !== 1'b1 || d0 !== 8'hA1 || l0 !== 1'b0) begin
         n_fail++; $display("FAIL stall_head: got valid=%0b data=%02h last=%0b want 1,a1,0", o_valid, d0, l0);
      end
      repeat (5) @(negedge clk);
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== d0 || o_last !== l0) begin
         n_fail++; $display("FAIL stall_hold: got valid=%0b data=%02h last=%0b want 1,%02h,%0b",
                            o_valid, o_data, o_last, d0, l0);
      end
      @(posedge clk); #1;
      i_ready = 1'b1;
      wait_drain("b2b");
   endtask

   task automatic test_sync_and_reset();
      int ok0, dr0;
      drive(1'b1, 8'h00); drive(1'b0, 8'h01); drive(1'b0, 8'h02);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midframe_reset_outputs");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      ok0 = ok_cnt; dr0 = drop_cnt;
      drive(1'b0, 8'h11); drive(1'b0, 8'h22);
      frm = '{8'h01, 8'h02, 8'h03};
      send_frame(1'b0, 1'b1);
      wait_drain("sync");
      n_checks++;
      if (ok_cnt - ok0 !== 1 || drop_cnt != dr0) begin
         n_fail++; $display("FAIL sync_discard: got ok=%0d drop=%0d want 1,0", ok_cnt - ok0, drop_cnt - dr0);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_crc();
      test_runt_and_empty();
      test_overflow();
      test_back_to_back();
      test_sync_and_reset();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_leftover: got %0d pending want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
